muldiv_unit: RTL and testbench
==============================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 The block SHALL have one parameter: SPECIAL_FAST, default 1, meaning that divide-by-zero and signed-overflow divisions complete without iterating.
REQ-002 The block SHALL have one clock and an asynchronous, active-high reset; the ports are listed in REQ-003 to REQ-013.
REQ-003 Port `clk`, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 Port `rst`, input, 1 bit: asynchronous, active-high reset.
REQ-005 Port `MDstart`, input, 1 bit: request a new operation; sampled only in IDLE.
REQ-006 Port `MDop`, input, 3 bits: funct3 of the RV32M instruction.
- 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU.
- 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-007 Port `MDoperand1`, input, 32 bits: rs1 value (multiplicand/dividend), taken from register-file read port 1.
REQ-008 Port `MDoperand2`, input, 32 bits: rs2 value (multiplier/divisor), taken from register-file read port 2.
REQ-009 Port `MDdestination_register`, input, 5 bits: rd index of the requesting instruction.
REQ-010 Port `MDbusy`, output, 1 bit: operation in progress; the core stalls the PC while it is high.
REQ-011 Port `MDdone`, output, 1 bit: one-cycle pulse; result valid; the core asserts the register-file write enable in this cycle.
REQ-012 Port `MDresult`, output, 32 bits: result; feeds the register-file write data.
REQ-013 Port `MDdestination_out`, output, 5 bits: latched rd; feeds the register-file destination.

Function
REQ-014 The FSM SHALL have exactly the states IDLE, RUN and DONE.
REQ-015 IDLE->RUN SHALL occur on a rising edge with MDstart=1; operands, op and rd are captured at that edge.
REQ-016 In IDLE, MDstart=0 SHALL hold the FSM in IDLE.
REQ-017 RUN SHALL perform exactly 32 iterations, one per cycle, using a 6-bit counter.
- Multiply: radix-2 shift-add into a 64-bit product.
- Divide: restoring division on magnitudes.
REQ-018 RUN->DONE SHALL occur after the 32nd iteration, so MDdone rises in cycle 33 after the start edge.
REQ-019 DONE->IDLE SHALL occur unconditionally after one cycle.
REQ-020 MDbusy SHALL be 1 in RUN and DONE and 0 in IDLE.
REQ-021 MDdone SHALL be 1 only in DONE.
REQ-022 MDstart while MDbusy=1 SHALL be ignored, with no change to captured operands.
REQ-023 MUL SHALL return product[31:0]; MULH, MULHSU and MULHU SHALL return product[63:32].
REQ-024 Product signedness SHALL be: MULH signed x signed, MULHSU signed x unsigned, MULHU unsigned x unsigned.
REQ-025 Signed operations SHALL divide or multiply magnitudes and then apply the sign.
- Quotient sign = sign1 XOR sign2.
- Remainder sign = sign of the dividend.
REQ-026 Divide by zero SHALL return:
- DIV/DIVU quotient 0xFFFFFFFF.
- REM/REMU remainder = MDoperand1.
REQ-027 DIV/REM with 0x80000000 / 0xFFFFFFFF SHALL return quotient 0x80000000 and remainder 0.
REQ-028 With SPECIAL_FAST=1, the cases in REQ-026 and REQ-027 SHALL go IDLE->DONE directly, so MDdone is in cycle 1.
REQ-029 With SPECIAL_FAST=0, the cases in REQ-026 and REQ-027 SHALL take the normal 33-cycle path with the same result.
REQ-030 MDresult and MDdestination_out SHALL be registered and held stable from DONE until the next accepted start, so the register file's falling-edge write sees stable data.
REQ-031 Operands x0-sourced (value 0) SHALL need no special handling.
REQ-032 Writes to rd=0 SHALL be passed through unchanged; the register file discards them.

Reset
REQ-033 rst=1 SHALL asynchronously force:
- FSM to IDLE and counter to 0.
- MDbusy=0, MDdone=0.
- MDresult=0x00000000, MDdestination_out=0.
REQ-034 Reset during RUN or DONE SHALL abort the operation with no MDdone pulse, and the first rising edge after release SHALL sample MDstart normally.

Structure
REQ-035 A shared package SHALL hold:
- the MDop encodings (MD_MUL..MD_REMU);
- the state enum (IDLE, RUN, DONE);
- ITER_COUNT=32.
REQ-036 The block SHALL be a single module with no sub-modules; the sign-fixup logic is an internal function.

Verification
REQ-037 MUL with 7 x 6 SHALL give MDresult=0x0000002A with MDdone in cycle 33 and MDdestination_out equal to the captured rd.
REQ-038 MULH with 0xFFFFFFFF x 0xFFFFFFFF SHALL give 0x00000000; MULHU with the same operands SHALL give 0xFFFFFFFE.
REQ-039 DIV with -7/2 SHALL give 0xFFFFFFFD; REM with the same operands SHALL give 0xFFFFFFFF; DIVU with 7/2 SHALL give 0x00000003.
REQ-040 DIVU with 5/0 SHALL give 0xFFFFFFFF, and REM with 0x80000000/0xFFFFFFFF SHALL give 0; with SPECIAL_FAST=1, MDdone SHALL occur in cycle 1.
REQ-041 The bench SHALL assert MDstart with new operands in cycle 10 of a running MUL; the result SHALL be unaffected and MDdone SHALL still occur in cycle 33.
REQ-042 The bench SHALL assert rst in cycle 15 of a DIV; MDbusy SHALL go to 0 immediately, there SHALL be no MDdone, MDresult SHALL be 0, and a new DIVU 100/10 after release SHALL give 0x0000000A.

Source files
------------

// File: rtl/muldiv_unit_pkg.sv
// Shared definitions for the RV32M multiply/divide unit: op encodings, FSM states, sizes.
package muldiv_unit_pkg;

   localparam int unsigned XLEN       = 32;
   localparam int unsigned ITER_COUNT = 32;
   localparam int unsigned CNT_W      = 6;
   localparam int unsigned RD_W       = 5;

   typedef enum logic [2:0] {
      MD_MUL    = 3'b000,
      MD_MULH   = 3'b001,
      MD_MULHSU = 3'b010,
      MD_MULHU  = 3'b011,
      MD_DIV    = 3'b100,
      MD_DIVU   = 3'b101,
      MD_REM    = 3'b110,
      MD_REMU   = 3'b111
   } md_op_e;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10
   } md_state_e;

endpackage

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: 32-cycle shift-add multiply and restoring divide on
// magnitudes, sign applied at the end; divide-by-zero and overflow optionally short-circuited.
module muldiv_unit
   import muldiv_unit_pkg::*;
#(
   parameter bit SPECIAL_FAST = 1'b1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            MDstart,
   input  logic [2:0]      MDop,
   input  logic [XLEN-1:0] MDoperand1,
   input  logic [XLEN-1:0] MDoperand2,
   input  logic [RD_W-1:0] MDdestination_register,
   output logic            MDbusy,
   output logic            MDdone,
   output logic [XLEN-1:0] MDresult,
   output logic [RD_W-1:0] MDdestination_out
);

   md_state_e           state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [2*XLEN-1:0]   acc_q, acc_d;
   logic [XLEN-1:0]     opb_q, opb_d;
   md_op_e              op_q, op_d;
   logic                neg_q, neg_d;
   logic                special_q, special_d;
   logic [XLEN-1:0]     spec_res_q, spec_res_d;
   logic [XLEN-1:0]     result_q, result_d;
   logic [RD_W-1:0]     rd_q, rd_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;

   md_op_e              op_in;
   logic                is_div, a_signed, b_signed, a_neg, b_neg;
   logic [XLEN-1:0]     mag1, mag2;
   logic                div_zero, div_ovf, special_in, neg_in;
   logic [XLEN-1:0]     spec_res_in;
   logic [XLEN:0]       mul_sum;
   logic [2*XLEN-1:0]   mul_next;
   logic [XLEN:0]       div_tmp, div_diff;
   logic [2*XLEN-1:0]   div_next;

   // Apply the stored result sign to the magnitude datapath and select the requested half
   function automatic logic [XLEN-1:0] sign_fixup(input md_op_e op,
                                                  input logic [2*XLEN-1:0] acc,
                                                  input logic neg);
      logic [2*XLEN-1:0] prod;
      logic [XLEN-1:0]   quo, rem, res;
      prod = neg ? -acc : acc;
      quo  = neg ? -acc[XLEN-1:0] : acc[XLEN-1:0];
      rem  = neg ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
      unique case (op)
         MD_MUL:                        res = acc[XLEN-1:0];
         MD_MULH, MD_MULHSU, MD_MULHU:  res = prod[2*XLEN-1:XLEN];
         MD_DIV, MD_DIVU:               res = quo;
         default:                       res = rem;
      endcase
      return res;
   endfunction

   // Operand decode: signedness, magnitudes, special divide cases
   always_comb begin
      op_in    = md_op_e'(MDop);
      is_div   = MDop[2];
      a_signed = (op_in == MD_MULH) || (op_in == MD_MULHSU) ||
                 (op_in == MD_DIV)  || (op_in == MD_REM);
      b_signed = (op_in == MD_MULH) || (op_in == MD_DIV) || (op_in == MD_REM);
      a_neg    = a_signed && MDoperand1[XLEN-1];
      b_neg    = b_signed && MDoperand2[XLEN-1];
      mag1     = a_neg ? -MDoperand1 : MDoperand1;
      mag2     = b_neg ? -MDoperand2 : MDoperand2;

      unique case (op_in)
         MD_MULH, MD_MULHSU, MD_DIV: neg_in = a_neg ^ b_neg;
         MD_REM:                     neg_in = a_neg;
         default:                    neg_in = 1'b0;
      endcase

      div_zero   = is_div && (MDoperand2 == '0);
      div_ovf    = ((op_in == MD_DIV) || (op_in == MD_REM)) &&
                   (MDoperand1 == 32'h8000_0000) && (MDoperand2 == 32'hFFFF_FFFF);
      special_in = div_zero || div_ovf;
      if (div_zero) begin
         spec_res_in = MDop[1] ? MDoperand1 : 32'hFFFF_FFFF;
      end else begin
         spec_res_in = MDop[1] ? 32'h0000_0000 : 32'h8000_0000;
      end
   end

   // One iteration of each algorithm: acc holds {hi,lo} product or {remainder,quotient}
   always_comb begin
      mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : '0);
      mul_next = {mul_sum, acc_q[XLEN-1:1]};

      div_tmp  = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
      div_diff = div_tmp - {1'b0, opb_q};
      if (!div_diff[XLEN]) begin
         div_next = {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
      end else begin
         div_next = {div_tmp[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
      end
   end

   // Next-state and datapath control
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      acc_d      = acc_q;
      opb_d      = opb_q;
      op_d       = op_q;
      neg_d      = neg_q;
      special_d  = special_q;
      spec_res_d = spec_res_q;
      result_d   = result_q;
      rd_d       = rd_q;

      unique case (state_q)
         IDLE: begin
            if (MDstart) begin
               op_d       = op_in;
               rd_d       = MDdestination_register;
               neg_d      = neg_in;
               special_d  = special_in;
               spec_res_d = spec_res_in;
               cnt_d      = '0;
               acc_d      = is_div ? {{XLEN{1'b0}}, mag1} : {{XLEN{1'b0}}, mag2};
               opb_d      = is_div ? mag2 : mag1;
               if (SPECIAL_FAST && special_in) begin
                  state_d  = DONE;
                  result_d = spec_res_in;
               end else begin
                  state_d  = RUN;
               end
            end
         end
         RUN: begin
            acc_d = op_q[2] ? div_next : mul_next;
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(ITER_COUNT - 1)) begin
               state_d  = DONE;
               result_d = special_q ? spec_res_q : sign_fixup(op_q, acc_d, neg_q);
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      busy_d = (state_d != IDLE);
      done_d = (state_d == DONE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         acc_q      <= '0;
         opb_q      <= '0;
         op_q       <= MD_MUL;
         neg_q      <= 1'b0;
         special_q  <= 1'b0;
         spec_res_q <= '0;
         result_q   <= '0;
         rd_q       <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         acc_q      <= acc_d;
         opb_q      <= opb_d;
         op_q       <= op_d;
         neg_q      <= neg_d;
         special_q  <= special_d;
         spec_res_q <= spec_res_d;
         result_q   <= result_d;
         rd_q       <= rd_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   assign MDbusy            = busy_q;
   assign MDdone            = done_q;
   assign MDresult          = result_q;
   assign MDdestination_out = rd_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: fast and non-fast special-case instances driven in parallel.
module tb_muldiv_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        MDstart;
   logic [2:0]  MDop;
   logic [31:0] MDoperand1, MDoperand2;
   logic [4:0]  MDdestination_register;

   logic        busy_f, done_f, busy_s, done_s;
   logic [31:0] result_f, result_s;
   logic [4:0]  dest_f, dest_s;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   muldiv_unit #(.SPECIAL_FAST(1'b1)) u_fast (
      .clk(clk), .rst(rst), .MDstart(MDstart), .MDop(MDop),
      .MDoperand1(MDoperand1), .MDoperand2(MDoperand2),
      .MDdestination_register(MDdestination_register),
      .MDbusy(busy_f), .MDdone(done_f), .MDresult(result_f), .MDdestination_out(dest_f)
   );

   muldiv_unit #(.SPECIAL_FAST(1'b0)) u_slow (
      .clk(clk), .rst(rst), .MDstart(MDstart), .MDop(MDop),
      .MDoperand1(MDoperand1), .MDoperand2(MDoperand2),
      .MDdestination_register(MDdestination_register),
      .MDbusy(busy_s), .MDdone(done_s), .MDresult(result_s), .MDdestination_out(dest_s)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Launch one op and wait (bounded) for MDdone on both instances; cycle 1 = right after start edge
   task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd,
                         output int cyc_f, output logic [31:0] res_f,
                         output int cyc_s, output logic [31:0] res_s);
      @(negedge clk);
      MDop = op; MDoperand1 = a; MDoperand2 = b; MDdestination_register = rd; MDstart = 1'b1;
      @(posedge clk); #1;
      MDstart = 1'b0;
      cyc_f = -1; cyc_s = -1; res_f = '0; res_s = '0;
      for (int c = 1; c <= 40; c++) begin
         if (cyc_f < 0 && done_f) begin cyc_f = c; res_f = result_f; end
         if (cyc_s < 0 && done_s) begin cyc_s = c; res_s = result_s; end
         if (cyc_f >= 0 && cyc_s >= 0) break;
         @(posedge clk); #1;
      end
   endtask

   task automatic do_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd,
                        input logic [31:0] exp, input int exp_cyc_f);
      int cf, cs;
      logic [31:0] rf, rs;
      run_op(op, a, b, rd, cf, rf, cs, rs);
      check({tag, "_res_fast"}, 64'(rf), 64'(exp));
      check({tag, "_res_slow"}, 64'(rs), 64'(exp));
      check({tag, "_cyc_fast"}, 64'(cf), 64'(exp_cyc_f));
      check({tag, "_cyc_slow"}, 64'(cs), 64'(33));
      check({tag, "_rd"}, 64'(dest_f), 64'(rd));
      @(posedge clk); #1;
      check({tag, "_idle_busy"}, 64'(busy_f), 64'(0));
      check({tag, "_idle_done"}, 64'(done_s), 64'(0));
      check({tag, "_hold_res"}, 64'(result_s), 64'(exp));
   endtask

   initial begin
      int cyc, cyc_done;
      logic saw_done;

      rst = 1'b1; MDstart = 1'b0; MDop = '0; MDoperand1 = '0; MDoperand2 = '0;
      MDdestination_register = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy",   64'(busy_f),   64'(0));
      check("rst_done",   64'(done_f),   64'(0));
      check("rst_result", 64'(result_f), 64'(0));
      check("rst_dest",   64'(dest_f),   64'(0));
      @(negedge clk);
      rst = 1'b0;

      do_op("mul_7x6",     3'b000, 32'd7,          32'd6,          5'd5,  32'h0000_002A, 33);
      do_op("mul_neg",     3'b000, 32'hFFFF_FFFD,  32'd5,          5'd1,  32'hFFFF_FFF1, 33);
      do_op("mulh_m1m1",   3'b001, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd2,  32'h0000_0000, 33);
      do_op("mulhu_m1m1",  3'b011, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd3,  32'hFFFF_FFFE, 33);
      do_op("mulhsu_m1",   3'b010, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd4,  32'hFFFF_FFFF, 33);
      do_op("div_m7_2",    3'b100, 32'hFFFF_FFF9,  32'd2,          5'd6,  32'hFFFF_FFFD, 33);
      do_op("rem_m7_2",    3'b110, 32'hFFFF_FFF9,  32'd2,          5'd7,  32'hFFFF_FFFF, 33);
      do_op("divu_7_2",    3'b101, 32'd7,          32'd2,          5'd8,  32'h0000_0003, 33);
      do_op("remu_7_2",    3'b111, 32'd7,          32'd2,          5'd9,  32'h0000_0001, 33);
      do_op("rem_7_m2",    3'b110, 32'd7,          32'hFFFF_FFFE,  5'd10, 32'h0000_0001, 33);
      do_op("divu_5_0",    3'b101, 32'd5,          32'd0,          5'd11, 32'hFFFF_FFFF, 1);
      do_op("div_m5_0",    3'b100, 32'hFFFF_FFFB,  32'd0,          5'd12, 32'hFFFF_FFFF, 1);
      do_op("remu_5_0",    3'b111, 32'd5,          32'd0,          5'd13, 32'h0000_0005, 1);
      do_op("rem_ovf",     3'b110, 32'h8000_0000,  32'hFFFF_FFFF,  5'd14, 32'h0000_0000, 1);
      do_op("div_ovf",     3'b100, 32'h8000_0000,  32'hFFFF_FFFF,  5'd15, 32'h8000_0000, 1);
      do_op("mul_x0_rd0",  3'b000, 32'd0,          32'd1234,       5'd0,  32'h0000_0000, 33);

      // Start request with new operands during cycle 10 of a running MUL must be ignored
      @(negedge clk);
      MDop = 3'b000; MDoperand1 = 32'h0000_1234; MDoperand2 = 32'h10;
      MDdestination_register = 5'd9; MDstart = 1'b1;
      @(posedge clk); #1;
      MDstart = 1'b0;
      cyc_done = -1;
      for (int c = 1; c <= 40; c++) begin
         if (c == 10) begin
            MDstart = 1'b1; MDop = 3'b101; MDoperand1 = 32'd99; MDoperand2 = 32'd3;
            MDdestination_register = 5'd3;
         end else begin
            MDstart = 1'b0;
         end
         if (done_f) begin cyc_done = c; break; end
         @(posedge clk); #1;
      end
      MDstart = 1'b0;
      check("ignore_start_res", 64'(result_f), 64'h0001_2340);
      check("ignore_start_cyc", 64'(cyc_done), 64'(33));
      check("ignore_start_rd",  64'(dest_f),   64'(9));
      @(posedge clk); #1;

      // Reset in cycle 15 of a DIV aborts it with no done pulse
      @(negedge clk);
      MDop = 3'b100; MDoperand1 = 32'd100; MDoperand2 = 32'd7;
      MDdestination_register = 5'd20; MDstart = 1'b1;
      @(posedge clk); #1;
      MDstart = 1'b0;
      cyc = 1;
      while (cyc < 15) begin @(posedge clk); #1; cyc++; end
      check("mid_run_busy", 64'(busy_f), 64'(1));
      rst = 1'b1;
      #1;
      check("abort_busy_fast", 64'(busy_f),   64'(0));
      check("abort_busy_slow", 64'(busy_s),   64'(0));
      check("abort_result",    64'(result_f), 64'(0));
      check("abort_dest",      64'(dest_f),   64'(0));
      saw_done = 1'b0;
      repeat (3) begin
         @(posedge clk); #1;
         if (done_f || done_s) saw_done = 1'b1;
      end
      @(negedge clk);
      rst = 1'b0;
      repeat (30) begin
         @(posedge clk); #1;
         if (done_f || done_s) saw_done = 1'b1;
      end
      check("abort_no_done", 64'(saw_done), 64'(0));
      check("abort_result_held", 64'(result_f), 64'(0));
      do_op("divu_100_10", 3'b101, 32'd100, 32'd10, 5'd21, 32'h0000_000A, 33);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
